// File: rtl/game_text_buffer_if.sv
// game_text_buffer_if: write port of the character buffer.
//   master - game logic side: drives write requests and cursor loads.
//   slave  - buffer side: returns wr_ready and the current cursor.
// Signals:
//   wr_valid  write request
//   wr_ready  write accepted when high together with wr_valid
//   wr_cursor 1: write at the cursor, 0: write at wr_xy
//   wr_xy     explicit write address, or cursor load value ({row, col})
//   wr_code   write data
//   cur_load  load the cursor from wr_xy
//   cursor    current cursor address
`timescale 1ns/1ps
interface game_text_buffer_if #(
    parameter int unsigned AW     = 8,
    parameter int unsigned CODE_W = 7
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_cursor;
    logic [AW-1:0]     wr_xy;
    logic [CODE_W-1:0] wr_code;
    logic              cur_load;
    logic [AW-1:0]     cursor;

    modport master (
        output wr_valid, wr_cursor, wr_xy, wr_code, cur_load,
        input  wr_ready, cursor
    );

    modport slave (
        input  wr_valid, wr_cursor, wr_xy, wr_code, cur_load,
        output wr_ready, cursor
    );
endinterface

// File: rtl/game_text_buffer.sv
// game_text_buffer: writable COLS x ROWS character grid read by the text renderer.
// Reads have one cycle of registered latency and are read-first. Writes arrive on a
// ready/valid port at an explicit address or at an auto-incrementing cursor. A clear
// sequencer sweeps BLANK_CODE over the whole grid after reset and on clr_req; while it
// runs, writes are stalled and reads return BLANK_CODE.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   char_xy     read address {row, col}
//   char_code   registered read data
//   wr          write port (slave side of game_text_buffer_if)
//   clr_req     single-cycle pulse starting a full-grid clear
//   busy        clear in progress
`timescale 1ns/1ps
module game_text_buffer #(
    parameter int unsigned       COLS       = 16,
    parameter int unsigned       ROWS       = 8,
    parameter int unsigned       CODE_W     = 7,
    parameter logic [CODE_W-1:0] BLANK_CODE = 7'h20,
    localparam int unsigned      XW         = $clog2(COLS),
    localparam int unsigned      YW         = $clog2(ROWS),
    localparam int unsigned      AW         = XW + YW,
    localparam int unsigned      N          = COLS * ROWS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AW-1:0]         char_xy,
    output logic [CODE_W-1:0]     char_code,
    game_text_buffer_if.slave     wr,
    input  logic                  clr_req,
    output logic                  busy
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q;
    logic [AW-1:0]     clr_addr_q;
    logic [AW-1:0]     cursor_q;
    logic [CODE_W-1:0] mem [N];

    logic          wr_fire;
    logic [AW-1:0] wr_addr;

    assign busy        = (state_q == StClear);
    assign wr.wr_ready = ~busy;
    assign wr.cursor   = cursor_q;
    assign wr_fire     = wr.wr_valid & ~busy;
    // A cursor-mode write combined with cur_load targets the freshly loaded address.
    assign wr_addr     = (wr.wr_cursor && !wr.cur_load) ? cursor_q : wr.wr_xy;

    // Storage has no reset; only the clear sequencer initialises it.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_addr_q] <= BLANK_CODE;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr.wr_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
            cursor_q   <= '0;
            char_code  <= BLANK_CODE;
        end else begin
            // Sampled before this edge's write lands, so same-address reads see old data.
            char_code <= busy ? BLANK_CODE : mem[char_xy];

            unique case (state_q)
                StIdle: begin
                    if (clr_req) begin
                        state_q    <= StClear;
                        clr_addr_q <= '0;
                    end
                end
                StClear: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == AW'(N - 1)) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Entering a clear homes the cursor and wins over a simultaneous cur_load.
            if (state_q == StIdle && clr_req) begin
                cursor_q <= '0;
            end else if (wr.cur_load && wr_fire && wr.wr_cursor) begin
                cursor_q <= wr.wr_xy + 1'b1;
            end else if (wr.cur_load) begin
                cursor_q <= wr.wr_xy;
            end else if (wr_fire && wr.wr_cursor) begin
                cursor_q <= cursor_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_game_text_buffer.sv
// tb_game_text_buffer: directed bench for game_text_buffer (16 x 8 grid, 7-bit codes).
// A table of single-cycle vectors covers explicit/cursor writes, cursor loads, wrap and
// read-first behaviour; hand-written sequences cover reset release, clr_req with a
// simultaneous write, and reset asserted in the middle of a clear.
`timescale 1ns/1ps
module tb_game_text_buffer;

    localparam int N = 128;
    localparam logic [6:0] BLANK = 7'h20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] char_xy;
    logic [6:0] char_code;
    logic       clr_req;
    logic       busy;

    game_text_buffer_if #(.AW(8), .CODE_W(7)) wr_bus ();

    game_text_buffer #(
        .COLS       (16),
        .ROWS       (8),
        .CODE_W     (7),
        .BLANK_CODE (7'h20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .char_xy   (char_xy),
        .char_code (char_code),
        .wr        (wr_bus),
        .clr_req   (clr_req),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic       cur_mode;
        logic       load;
        logic [7:0] xy;
        logic [6:0] code;
        logic [7:0] rd_xy;
        logic [6:0] exp_code;
        logic [7:0] exp_cursor;
        logic       exp_ready;
    } vec_t;

    vec_t vecs [18];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_bus.wr_valid  = 1'b0;
        wr_bus.wr_cursor = 1'b0;
        wr_bus.wr_xy     = 8'h00;
        wr_bus.wr_code   = 7'h00;
        wr_bus.cur_load  = 1'b0;
        clr_req          = 1'b0;
    endtask

    // Counts the sweep that follows reset release: busy for exactly N edges.
    task automatic clear_count(input string tag);
        for (int k = 1; k <= N; k++) begin
            char_xy = 8'(k);
            step();
            check({tag, " busy"}, busy, k < N);
            check({tag, " wr_ready"}, wr_bus.wr_ready, k >= N);
            if (k < N) check({tag, " blank read"}, char_code, BLANK);
        end
    endtask

    function automatic logic [6:0] fill_code(input int i);
        return ~7'(i);
    endfunction

    initial begin
        //       valid cur load xy     code   rd_xy  exp    cursor rdy
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h35, 7'h41, 8'h35, 7'h20, 8'h00, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 8'h35, 7'h41, 8'h00, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h7E, 7'h00, 8'h00, 7'h20, 8'h7E, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 7'h41, 8'h7E, 7'h20, 8'h7F, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 7'h42, 8'h7E, 7'h41, 8'h00, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 7'h43, 8'h7F, 7'h42, 8'h01, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 8'h00, 7'h43, 8'h01, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h10, 7'h44, 8'h01, 7'h20, 8'h11, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 8'h10, 7'h44, 8'h11, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 7'h45, 8'h01, 7'h20, 8'h12, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h0F, 7'h46, 8'h11, 7'h45, 8'h12, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 8'h0F, 7'h46, 8'h12, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h20, 7'h47, 8'h12, 7'h20, 8'h20, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 8'h20, 7'h47, 8'h20, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 7'h00, 8'h35, 7'h41, 8'h20, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 8'h2F, 7'h00, 8'h20, 7'h47, 8'h2F, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 8'h00, 7'h48, 8'h2F, 7'h20, 8'h30, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 8'h2F, 7'h48, 8'h30, 1'b1};

        idle_inputs();
        char_xy = 8'h00;

        // Reset values while held in reset.
        step();
        step();
        check("rst char_code", char_code, BLANK);
        check("rst busy", busy, 1'b1);
        check("rst wr_ready", wr_bus.wr_ready, 1'b0);
        check("rst cursor", wr_bus.cursor, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;
        clear_count("init");

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 18; i++) begin
            wr_bus.wr_valid  = vecs[i].valid;
            wr_bus.wr_cursor = vecs[i].cur_mode;
            wr_bus.cur_load  = vecs[i].load;
            wr_bus.wr_xy     = vecs[i].xy;
            wr_bus.wr_code   = vecs[i].code;
            char_xy          = vecs[i].rd_xy;
            step();
            check($sformatf("vec%0d char_code", i), char_code, vecs[i].exp_code);
            check($sformatf("vec%0d cursor", i), wr_bus.cursor, vecs[i].exp_cursor);
            check($sformatf("vec%0d wr_ready", i), wr_bus.wr_ready, vecs[i].exp_ready);
        end
        idle_inputs();

        // Fill the whole grid with explicit writes, then read it back.
        for (int i = 0; i < N; i++) begin
            wr_bus.wr_valid = 1'b1;
            wr_bus.wr_xy    = 8'(i);
            wr_bus.wr_code  = fill_code(i);
            step();
        end
        idle_inputs();
        check("fill cursor", wr_bus.cursor, 8'h30);
        for (int i = 0; i < N; i++) begin
            char_xy = 8'(i);
            step();
            check($sformatf("fill rd %0h", i), char_code, fill_code(i));
        end

        // clr_req with a simultaneous write; writes held pending through the sweep.
        clr_req          = 1'b1;
        wr_bus.wr_valid  = 1'b1;
        wr_bus.wr_cursor = 1'b0;
        wr_bus.wr_xy     = 8'h05;
        wr_bus.wr_code   = 7'h7F;
        char_xy          = 8'h05;
        step();
        check("clr start busy", busy, 1'b1);
        check("clr start wr_ready", wr_bus.wr_ready, 1'b0);
        check("clr start cursor", wr_bus.cursor, 8'h00);
        check("clr start read-first", char_code, fill_code(5));
        for (int k = 1; k <= N; k++) begin
            clr_req = (k == 100);
            step();
            check("clr busy", busy, k < N);
            check("clr wr_ready", wr_bus.wr_ready, k >= N);
            check("clr read blank", char_code, BLANK);
            check("clr cursor", wr_bus.cursor, 8'h00);
        end
        idle_inputs();
        for (int i = 0; i < N; i++) begin
            char_xy = 8'(i);
            step();
            check($sformatf("cleared rd %0h", i), char_code, BLANK);
        end

        // Reset in the middle of a clear; cur_load is still honoured during the sweep.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 1; k < 40; k++) begin
            wr_bus.cur_load = (k == 20);
            wr_bus.wr_xy    = 8'h33;
            step();
        end
        idle_inputs();
        check("mid clr cursor load", wr_bus.cursor, 8'h33);
        check("mid clr busy", busy, 1'b1);
        rst_n = 1'b0;
        #2;
        check("rst2 busy", busy, 1'b1);
        check("rst2 wr_ready", wr_bus.wr_ready, 1'b0);
        check("rst2 cursor", wr_bus.cursor, 8'h00);
        check("rst2 char_code", char_code, BLANK);
        @(negedge clk);
        rst_n = 1'b1;
        clear_count("rst2");

        // Post-recovery write and read.
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_xy    = 8'h7F;
        wr_bus.wr_code  = 7'h11;
        char_xy         = 8'h7F;
        step();
        check("final read-first", char_code, BLANK);
        idle_inputs();
        step();
        check("final read", char_code, 7'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
